// File: rtl/div_int_sgn_if.sv
// Handshake and operand/result bundle for the iterative signed/unsigned divider.
interface div_int_sgn_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             valid;
    logic             dbz;
    logic             ovf;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output start, sgn, x, y,
        input  busy, valid, dbz, ovf, q, r
    );

    modport slave (
        input  start, sgn, x, y,
        output busy, valid, dbz, ovf, q, r
    );
endinterface

// File: rtl/div_int_sgn.sv
// Radix-2 restoring divider, one quotient bit per clock, with a per-operation
// signed/unsigned mode, divide-by-zero and MIN/-1 overflow flags.
module div_int_sgn #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    div_int_sgn_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_neg;
    logic             r_neg;
    logic             valid_r;
    logic             dbz_r;
    logic             ovf_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;

    logic             accept;
    logic             y_zero;
    logic             is_ovf;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;

    // Magnitude of a possibly-signed operand; |MIN| = 2^(WIDTH-1) is representable unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
        return s ? (~v + 1'b1) : v;
    endfunction

    assign accept = bus.start && (state == IDLE);
    assign y_zero = (bus.y == '0);
    assign is_ovf = bus.sgn && (bus.x == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.y);

    // A borrow out of the trial subtraction means the divisor did not fit.
    assign trial = {acc, quo[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};
    assign take  = ~diff[WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !y_zero && !is_ovf) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers carry no reset; they are fully reloaded on every accept.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    acc   <= '0;
                    quo   <= mag(bus.x, bus.sgn);
                    dvs   <= mag(bus.y, bus.sgn);
                    q_neg <= (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]) & bus.sgn;
                    r_neg <= bus.x[WIDTH-1] & bus.sgn;
                end
            end
            CALC: begin
                acc <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], take};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            valid_r <= 1'b0;
            dbz_r   <= 1'b0;
            ovf_r   <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        valid_r <= 1'b0;
                        dbz_r   <= 1'b0;
                        ovf_r   <= 1'b0;
                        if (y_zero) begin
                            dbz_r   <= 1'b1;
                            valid_r <= 1'b1;
                            q_r     <= '0;
                            r_r     <= '0;
                        end else if (is_ovf) begin
                            ovf_r   <= 1'b1;
                            valid_r <= 1'b1;
                            q_r     <= '0;
                            r_r     <= '0;
                        end
                    end
                end
                CALC: cnt <= cnt + 1'b1;
                FIX: begin
                    q_r     <= neg_if(quo, q_neg);
                    r_r     <= neg_if(acc, r_neg);
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.valid = valid_r;
    assign bus.dbz   = dbz_r;
    assign bus.ovf   = ovf_r;
    assign bus.q     = q_r;
    assign bus.r     = r_r;
endmodule

// File: tb/tb_div_int_sgn.sv
// Scoreboard bench for div_int_sgn: directed and random 8-bit operations plus an
// exhaustive 4-bit sweep, checked against an integer-arithmetic reference model.
module tb_div_int_sgn;
    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t sb8[$];
    exp_t sb4[$];

    div_int_sgn_if #(.WIDTH(8)) d8 ();
    div_int_sgn_if #(.WIDTH(4)) d4 ();

    div_int_sgn #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(d8));
    div_int_sgn #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(d4));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: plain integer division (truncating toward zero, remainder takes dividend sign).
    function automatic exp_t model(input int x, input int y, input bit s, input int w);
        exp_t e;
        int xi, yi, mask;
        mask = (1 << w) - 1;
        xi = x;
        yi = y;
        if (s && x >= (1 << (w - 1))) xi = x - (1 << w);
        if (s && y >= (1 << (w - 1))) yi = y - (1 << w);
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.lat = w + 1;
        if (y == 0) begin
            e.dbz = 1'b1; e.q = 8'd0; e.r = 8'd0; e.lat = 0;
        end else if (s && xi == -(1 << (w - 1)) && yi == -1) begin
            e.ovf = 1'b1; e.q = 8'd0; e.r = 8'd0; e.lat = 0;
        end else begin
            e.q = 8'((xi / yi) & mask);
            e.r = 8'((xi % yi) & mask);
        end
        return e;
    endfunction

    // Monitors: a result appears on an edge that leaves busy low after either an accept or a busy cycle.
    int   since8 = 0, bcnt8 = 0, since4 = 0, bcnt4 = 0;
    logic acc8, bp8, rp8, acc4, bp4, rp4;
    exp_t e8, e4;

    always @(posedge clk) begin
        rp8 = rst;
        acc8 = d8.start && !d8.busy && !rst;
        bp8 = d8.busy;
        #1;
        if (rp8) begin
            since8 = 0; bcnt8 = 0;
        end else begin
            if (acc8) begin since8 = 0; bcnt8 = 0; end
            else since8++;
            if (d8.busy) bcnt8++;
            if (!d8.busy && (acc8 || bp8)) begin
                if (sb8.size() == 0) chk("w8 unexpected result", 1, 0);
                else begin
                    e8 = sb8.pop_front();
                    chk("w8 valid", int'(d8.valid), 1);
                    chk("w8 q", int'(d8.q), int'(e8.q));
                    chk("w8 r", int'(d8.r), int'(e8.r));
                    chk("w8 dbz", int'(d8.dbz), int'(e8.dbz));
                    chk("w8 ovf", int'(d8.ovf), int'(e8.ovf));
                    chk("w8 latency", since8, e8.lat);
                    chk("w8 busy cycles", bcnt8, e8.lat);
                end
            end
        end
    end

    always @(posedge clk) begin
        rp4 = rst;
        acc4 = d4.start && !d4.busy && !rst;
        bp4 = d4.busy;
        #1;
        if (rp4) begin
            since4 = 0; bcnt4 = 0;
        end else begin
            if (acc4) begin since4 = 0; bcnt4 = 0; end
            else since4++;
            if (d4.busy) bcnt4++;
            if (!d4.busy && (acc4 || bp4)) begin
                if (sb4.size() == 0) chk("w4 unexpected result", 1, 0);
                else begin
                    e4 = sb4.pop_front();
                    chk("w4 valid", int'(d4.valid), 1);
                    chk("w4 q", int'(d4.q), int'(e4.q));
                    chk("w4 r", int'(d4.r), int'(e4.r));
                    chk("w4 dbz", int'(d4.dbz), int'(e4.dbz));
                    chk("w4 ovf", int'(d4.ovf), int'(e4.ovf));
                    chk("w4 latency", since4, e4.lat);
                    chk("w4 busy cycles", bcnt4, e4.lat);
                end
            end
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 24 && d8.busy; i++) @(negedge clk);
        if (d8.busy) chk("w8 timeout", 1, 0);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s);
        @(negedge clk);
        d8.x = x; d8.y = y; d8.sgn = s; d8.start = 1'b1;
        sb8.push_back(model(int'(x), int'(y), s, 8));
        @(negedge clk);
        d8.start = 1'b0;
        d8.x = 8'($urandom); d8.y = 8'($urandom); d8.sgn = 1'($urandom);
        wait_idle8();
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input bit s);
        @(negedge clk);
        d4.x = x; d4.y = y; d4.sgn = s; d4.start = 1'b1;
        sb4.push_back(model(int'(x), int'(y), s, 4));
        @(negedge clk);
        d4.start = 1'b0;
        d4.x = 4'($urandom); d4.y = 4'($urandom); d4.sgn = 1'($urandom);
        for (int i = 0; i < 16 && d4.busy; i++) @(negedge clk);
        if (d4.busy) chk("w4 timeout", 1, 0);
    endtask

    task automatic chk_zero8(input string nm);
        chk({nm, " busy"}, int'(d8.busy), 0);
        chk({nm, " valid"}, int'(d8.valid), 0);
        chk({nm, " dbz"}, int'(d8.dbz), 0);
        chk({nm, " ovf"}, int'(d8.ovf), 0);
        chk({nm, " q"}, int'(d8.q), 0);
        chk({nm, " r"}, int'(d8.r), 0);
    endtask

    initial begin
        d8.start = 1'b0; d8.sgn = 1'b0; d8.x = '0; d8.y = '0;
        d4.start = 1'b0; d4.sgn = 1'b0; d4.x = '0; d4.y = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero8("reset");
        chk("reset w4 busy", int'(d4.busy), 0);
        chk("reset w4 valid", int'(d4.valid), 0);
        rst = 1'b0;

        // Start while busy is ignored
        @(negedge clk);
        d8.x = 8'd100; d8.y = 8'd9; d8.sgn = 1'b0; d8.start = 1'b1;
        sb8.push_back(model(100, 9, 1'b0, 8));
        @(negedge clk);
        d8.start = 1'b0;
        repeat (2) @(negedge clk);
        d8.x = 8'd3; d8.y = 8'd1; d8.sgn = 1'b1; d8.start = 1'b1;
        @(negedge clk);
        d8.start = 1'b0;
        wait_idle8();

        // Signed cases, MIN handling and overflow vs unsigned
        op8(8'hF9, 8'h02, 1'b1);
        op8(8'h07, 8'hFE, 1'b1);
        op8(8'h80, 8'h02, 1'b1);
        op8(8'h80, 8'h01, 1'b1);
        op8(8'h80, 8'hFF, 1'b1);
        op8(8'h80, 8'hFF, 1'b0);
        op8(8'h7F, 8'hFF, 1'b1);
        op8(8'hFF, 8'h01, 1'b0);

        // Divide by zero, then recovery
        op8(8'd55, 8'd0, 1'b0);
        op8(8'd55, 8'd0, 1'b1);
        op8(8'd55, 8'd5, 1'b0);

        // Reset on the 4th CALC edge aborts with no result
        @(negedge clk);
        d8.x = 8'd200; d8.y = 8'd7; d8.sgn = 1'b0; d8.start = 1'b1;
        @(negedge clk);
        d8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero8("mid-op reset");
        rst = 1'b0;
        op8(8'd200, 8'd7, 1'b0);

        // Random 8-bit traffic
        for (int i = 0; i < 60; i++)
            op8(8'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom), 1'($urandom));

        // Exhaustive 4-bit sweep, both modes
        for (int s = 0; s < 2; s++)
            for (int xv = 0; xv < 16; xv++)
                for (int yv = 0; yv < 16; yv++)
                    op4(4'(xv), 4'(yv), 1'(s));

        repeat (4) @(negedge clk);
        chk("w8 outstanding", sb8.size(), 0);
        chk("w4 outstanding", sb4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_int_sgn.md
Name: div_int_sgn

Overview:
Iterative restoring integer divider. It is the parametrised successor of the unsigned radix-2 divider, with these additions:
- a signed/unsigned mode chosen per operation;
- a synchronous reset;
- signed-overflow detection;
- a fixed, documented latency.

One quotient bit is produced per clock. It serves arithmetic datapaths that need occasional division without a combinational divider.

Parameters:
WIDTH  8  operand/result width in bits; legal range WIDTH >= 2

Ports:
clk    input   1      clock; all logic on rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request a division; sampled only when busy=0
sgn    input   1      1 = two's-complement signed operation, 0 = unsigned; sampled with start
x      input   WIDTH  dividend; sampled with start
y      input   WIDTH  divisor; sampled with start
busy   output  1      calculation in progress
valid  output  1      q/r hold the result of the last accepted operation
dbz    output  1      last accepted operation had y==0
ovf    output  1      last accepted operation was signed MIN/-1
q      output  WIDTH  quotient
r      output  WIDTH  remainder

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset: when rst=1 at an edge, busy, valid, dbz, ovf, q and r are all 0 and the FSM goes to IDLE. Reset overrides start and aborts any in-flight operation with no result. The first start is accepted on the edge after rst deasserts.
- States: IDLE, CALC, FIX.
- Start acceptance: start is accepted at an edge where busy=0 and rst=0, in IDLE or after a completed operation. start while busy=1 is ignored; the in-flight operation is unaffected.
- On an accepted start:
  - valid, dbz and ovf clear to 0; q and r hold their old values.
  - If y==0: dbz=1, valid=1, q=0, r=0, busy stays 0, stay IDLE.
  - Else if sgn=1, x=100..0 and y=11..1: ovf=1, valid=1, q=0, r=0, busy stays 0, stay IDLE.
  - Else: latch |x|, |y| (sign magnitudes when sgn=1, raw values when sgn=0), the quotient sign (x[MSB]^y[MSB])&sgn and the remainder sign x[MSB]&sgn. Then busy=1 and go to CALC.
- CALC:
  - Runs exactly WIDTH edges, counted by an iteration counter of $clog2(WIDTH+1) bits.
  - Each edge performs one restoring step on a WIDTH+1-bit accumulator: if acc >= divisor, subtract and shift in 1; else shift in 0.
  - After the WIDTH-th step, go to FIX.
- FIX (one edge):
  - Negate the magnitude quotient if the quotient sign is set.
  - Negate the magnitude remainder if the remainder sign is set.
  - Drive q and r, valid=1, busy=0, return to IDLE.
- Latency: valid rises WIDTH+1 edges after the edge that accepted start. busy is high for exactly those WIDTH+1 cycles. Back-to-back operations are possible, giving a throughput of one result per WIDTH+2 cycles.
- Result semantics:
  - Unsigned: q=floor(x/y), r=x-q*y.
  - Signed: quotient truncates toward zero; r has the sign of x (or is 0); x = q*y + r always holds; |r| < |y|.
  - Magnitude of signed MIN is 2^(WIDTH-1), which must be handled in WIDTH bits without overflow, e.g. MIN/1 = MIN and MIN/2 = MIN/2.
- Hold: valid, dbz, ovf, q and r hold until the next accepted start or reset. At most one of dbz and ovf is set. dbz takes priority if both conditions apply; that cannot occur because y==0 is checked first.
- Unsampled inputs: changes to x, y or sgn while busy do not affect the result.

Test Plan:
1. Reset mid-operation. WIDTH=8, start x=200 y=7 sgn=0, assert rst on the 4th CALC edge. Required: all outputs 0 next edge. Then start x=200 y=7 → after 9 edges valid=1, q=28, r=4, busy deasserts the same edge.
2. Signed cases, WIDTH=8, sgn=1:
   - x=0xF9 (-7), y=0x02 → q=0xFD (-3), r=0xFF (-1).
   - x=0x07, y=0xFE (-2) → q=0xFD, r=0x01.
   - x=0x80 (-128), y=0x02 → q=0xC0 (-64), r=0.
3. Overflow vs unsigned, WIDTH=8:
   - sgn=1, x=0x80, y=0xFF → next edge valid=1, ovf=1, q=0, r=0, busy never high.
   - The same operands with sgn=0 → q=0x00, r=0x80 after 9 edges.
4. Divide by zero: x=55, y=0 (either mode) → next edge dbz=1, valid=1, q=r=0, busy=0. The following start with y=5 clears dbz on acceptance and yields q=11, r=0.
5. Start while busy: pulse start with new operands during CALC → ignored; the first result (x=100, y=9 → q=11, r=1) is delivered on time.
6. Exhaustive WIDTH=4 check: all 256 operand pairs in both modes against a reference model. Checks each result, that valid rises exactly 5 edges after accept, and that the flags match expectations.
